// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
// Shares one single-ported backing memory between the instruction fetch port
// (read-only) and the data port (read/write). Only one transaction can be in
// flight at a time. The data port normally wins a tie. A starvation counter
// lets a pending fetch win once STARVE_MAX data grants in a row have beaten it.
// A branch flush kills an in-flight fetch. The memory transaction still runs
// to completion, but no fetch response is produced.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   if_req_valid/addr/ready         fetch request handshake
//   if_flush                        kill in-flight fetch, block fetch grant
//   if_rsp_valid/data               one-cycle fetch response pulse
//   d_req_valid/we/addr/wdata/be    data request
//   d_req_ready                     data request accepted
//   d_rsp_valid/data                one-cycle data response pulse
//   mem_req_valid/we/addr/wdata/be  registered request to backing memory
//   mem_req_ready                   memory accepts request
//   mem_rsp_valid/data              memory response / write ack
module imem_dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    input  logic                if_flush,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                d_req_valid,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_be,
    output logic                d_req_ready,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data,
    output logic                mem_req_valid,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_be,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    state_t              state_reg, state_next;
    owner_t              owner_reg;
    logic                kill_reg;
    logic [CNT_W-1:0]    starve_cnt_reg;

    logic                mem_req_valid_reg;
    logic                mem_req_we_reg;
    logic [ADDR_W-1:0]   mem_req_addr_reg;
    logic [DATA_W-1:0]   mem_req_wdata_reg;
    logic [BE_W-1:0]     mem_req_be_reg;
    logic                if_rsp_valid_reg;
    logic [DATA_W-1:0]   if_rsp_data_reg;
    logic                d_rsp_valid_reg;
    logic [DATA_W-1:0]   d_rsp_data_reg;

    logic                fetch_elig;
    logic                grant_fetch;
    logic                grant_data;
    logic                rsp_done;

    // A flushed fetch is never eligible, so a flush in IDLE blocks the grant.
    assign fetch_elig = if_req_valid && !if_flush;
    // Responses outside WAIT are protocol violations and are dropped.
    assign rsp_done   = (state_reg == WAIT) && mem_rsp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fetch_elig && (!d_req_valid || starve_cnt_reg == STARVE_LIM)) begin
                    grant_fetch = 1'b1;
                end else if (d_req_valid) begin
                    grant_data = 1'b1;
                end
                if (grant_fetch || grant_data) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Readys are combinational, so they are gated by reset. This keeps every
    // output at 0 while reset is held.
    assign if_req_ready = grant_fetch && !reset;
    assign d_req_ready  = grant_data && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_reg         <= OWN_FETCH;
            kill_reg          <= 1'b0;
            starve_cnt_reg    <= '0;
            mem_req_valid_reg <= 1'b0;
            mem_req_we_reg    <= 1'b0;
            mem_req_addr_reg  <= '0;
            mem_req_wdata_reg <= '0;
            mem_req_be_reg    <= '0;
            if_rsp_valid_reg  <= 1'b0;
            if_rsp_data_reg   <= '0;
            d_rsp_valid_reg   <= 1'b0;
            d_rsp_data_reg    <= '0;
        end else begin
            if_rsp_valid_reg <= 1'b0;
            d_rsp_valid_reg  <= 1'b0;

            if (grant_fetch) begin
                owner_reg         <= OWN_FETCH;
                kill_reg          <= 1'b0;
                mem_req_valid_reg <= 1'b1;
                mem_req_we_reg    <= 1'b0;
                mem_req_addr_reg  <= if_req_addr;
                mem_req_wdata_reg <= '0;
                mem_req_be_reg    <= '1;
                starve_cnt_reg    <= '0;
            end else if (grant_data) begin
                owner_reg         <= OWN_DATA;
                kill_reg          <= 1'b0;
                mem_req_valid_reg <= 1'b1;
                mem_req_we_reg    <= d_req_we;
                mem_req_addr_reg  <= d_req_addr;
                mem_req_wdata_reg <= d_req_wdata;
                mem_req_be_reg    <= d_req_be;
                // Only a data grant that beats a waiting fetch counts as starvation.
                if (if_req_valid && starve_cnt_reg != STARVE_LIM) begin
                    starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
                end
            end

            // Fields stay latched after the handshake; only valid drops.
            if (state_reg == REQ && mem_req_ready) begin
                mem_req_valid_reg <= 1'b0;
            end

            if (owner_reg == OWN_FETCH && if_flush && (state_reg == REQ || state_reg == WAIT)) begin
                kill_reg <= 1'b1;
            end

            if (rsp_done) begin
                if (owner_reg == OWN_DATA) begin
                    d_rsp_valid_reg <= 1'b1;
                    d_rsp_data_reg  <= mem_rsp_data;
                end else if (!kill_reg && !if_flush) begin
                    // A flush in the response cycle itself also kills the fetch.
                    if_rsp_valid_reg <= 1'b1;
                    if_rsp_data_reg  <= mem_rsp_data;
                end
            end
        end
    end

    assign mem_req_valid = mem_req_valid_reg;
    assign mem_req_we    = mem_req_we_reg;
    assign mem_req_addr  = mem_req_addr_reg;
    assign mem_req_wdata = mem_req_wdata_reg;
    assign mem_req_be    = mem_req_be_reg;
    assign if_rsp_valid  = if_rsp_valid_reg;
    assign if_rsp_data   = if_rsp_data_reg;
    assign d_rsp_valid   = d_rsp_valid_reg;
    assign d_rsp_data    = d_rsp_data_reg;

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-ported backing memory between the fetch stage (read-only instruction port) and the memory stage (read/write data port) of the 5-stage core.
- Allows one outstanding transaction at a time.
- Data port has priority by default; a starvation counter guarantees fetch progress.
- Fetch transactions can be killed by a branch flush: they complete on the memory side, but the fetch response is suppressed.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_MAX, 4, consecutive data grants that lose to a pending fetch before fetch wins the next tie (>=1)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
if_req_valid  in  1  fetch read request
if_req_addr  in  ADDR_W  fetch address
if_req_ready  out  1  fetch request accepted this cycle (valid&&ready)
if_flush  in  1  branch flush: kill any fetch in flight, block fetch grant this cycle
if_rsp_valid  out  1  one-cycle pulse, fetch data valid
if_rsp_data  out  DATA_W  fetched instruction
d_req_valid  in  1  data request
d_req_we  in  1  1=write, 0=read
d_req_addr  in  ADDR_W  data address
d_req_wdata  in  DATA_W  write data
d_req_be  in  DATA_W/8  byte enables
d_req_ready  out  1  data request accepted this cycle
d_rsp_valid  out  1  one-cycle pulse, data access complete (reads and writes)
d_rsp_data  out  DATA_W  read data (= mem_rsp_data for writes, don't-care)
mem_req_valid  out  1  request to backing memory
mem_req_we  out  1  write strobe
mem_req_addr  out  ADDR_W  address
mem_req_wdata  out  DATA_W  write data
mem_req_be  out  DATA_W/8  byte enables
mem_req_ready  in  1  memory accepts request
mem_rsp_valid  in  1  memory response/ack (reads and writes)
mem_rsp_data  in  DATA_W  read data

Behaviour:
- FSM states: IDLE, REQ, WAIT. Owner register: FETCH or DATA. Kill flag: `kill`.
- **Reset:** state=IDLE, starve_cnt=0, kill=0. All outputs 0, including the mem_req_* fields and both rsp_valid/rsp_data.
- **Arbitration (IDLE only):**
  - Eligible fetch = if_req_valid && !if_flush.
  - If both data and eligible fetch are requesting: data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
  - If only one requests, it wins.
  - Winner's ready=1 combinationally in that cycle; loser's ready=0. Both readys are 0 outside IDLE.
- **Accept (cycle N):**
  - Latch the winner's request into the mem_req_* registers; set owner; clear kill; go to REQ.
  - mem_req_valid=1 from cycle N+1.
- **REQ:**
  - Hold mem_req_valid and all fields stable until mem_req_ready.
  - On mem_req_ready: mem_req_valid=0 next cycle; go to WAIT.
- **WAIT:**
  - On mem_rsp_valid: go to IDLE.
  - Load the response register of the owner; its rsp_valid pulses exactly one cycle later, with data = mem_rsp_data.
  - Minimum accept-to-rsp_valid latency is 3 cycles, with mem_req_ready=1 and the response arriving the cycle after acceptance.
- **Back-to-back:** the IDLE cycle in which rsp_valid pulses may accept a new request.
- **Flush:**
  - if_flush while owner==FETCH in REQ or WAIT sets kill.
  - The transaction still completes on memory, but if_rsp_valid stays 0.
  - if_flush in the same cycle mem_rsp_valid arrives for a fetch also suppresses the response.
  - if_flush has no effect on data transactions.
- **Starvation counter:**
  - On a data grant while if_req_valid=1: increment, saturating at STARVE_MAX.
  - On a fetch grant: clear to 0.
  - Otherwise: hold. Width = $clog2(STARVE_MAX+1).
- **Protocol guards:**
  - mem_rsp_valid in IDLE or REQ is ignored.
  - mem_req_ready outside REQ is ignored.
- **Reset mid-operation:** returns immediately to IDLE with all outputs 0. Late mem_rsp_valid for the aborted transaction is ignored (arrives in IDLE).
- **Requesters:** must hold valid and fields stable until ready; dropping valid before ready is legal and cancels the request.

Test Plan:
1. Single fetch: if_req_addr=0x100, mem_req_ready=1, memory replies 0x00500093 two cycles after mem_req_valid → mem_req_addr=0x100, mem_req_we=0; if_rsp_valid high exactly one cycle with 0x00500093; d_rsp_valid never asserts.
2. Simultaneous requests: fetch 0x104 and data read 0x80 in the same cycle, starve_cnt=0 → d_req_ready=1, if_req_ready=0; data response 0x11223344 on d_rsp_data. Fetch is accepted in the IDLE cycle where d_rsp_valid pulses, and completes next.
3. Starvation: STARVE_MAX=4, if_req_valid and d_req_valid held high continuously → grant order D,D,D,D,F, then D again; starve_cnt reads 4 before the fetch grant and 0 after.
4. Write with backpressure: d_req_we=1, addr 0x40, wdata 0xDEADBEEF, be 4'b0011, mem_req_ready low for 3 cycles → mem_req_* fields constant and mem_req_valid high for those 3 cycles plus the accept cycle; d_rsp_valid pulses once after mem_rsp_valid.
5. Flush: fetch 0x200 accepted, if_flush pulsed in WAIT, memory then responds → no if_rsp_valid. Next fetch 0x204 returns its data normally; if_flush in IDLE with if_req_valid=1 yields if_req_ready=0 that cycle.
6. Reset in WAIT: reset asserted while awaiting a data read → all outputs 0 in the same cycle (asynchronous). mem_rsp_valid arriving after reset release produces no d_rsp_valid, and a subsequent fetch completes normally.
